// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and helpers for the data-memory initiator.
//   mem_op_e   : load/store opcode encoding seen on REQ_OP
//   state_e    : controller FSM states
//   mem_req_t  : registered request fields (tag is held separately
//                because its width is a per-instance parameter)
//   CENABLE/CDISABLE/WENABLE/WDISABLE : data_ram strobe levels (active-low)
// Helpers: op_is_store, op_lane_sel, op_store_data, op_misaligned.
package data_mem_ctrl_pkg;

    localparam int DATA_W      = 32;
    localparam int DATA_ADDR_W = 32;

    localparam logic CENABLE  = 1'b0;
    localparam logic CDISABLE = 1'b1;
    localparam logic WENABLE  = 1'b0;
    localparam logic WDISABLE = 1'b1;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LBU = 3'd1,
        OP_LH  = 3'd2,
        OP_LHU = 3'd3,
        OP_LW  = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } mem_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef struct packed {
        mem_op_e                op;
        logic [DATA_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]      wdata;
    } mem_req_t;

    function automatic logic op_is_store(input mem_op_e op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    // Low address bits beyond the access size are ignored here, which is
    // the truncation rule used when alignment checking is disabled.
    function automatic logic [3:0] op_lane_sel(input mem_op_e op, input logic [1:0] lo);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 4'b0001 << lo;
            OP_LH, OP_LHU, OP_SH: return lo[1] ? 4'b1100 : 4'b0011;
            default:              return 4'b1111;
        endcase
    endfunction

    // Replicate store data across lanes so BYTE_SEL alone picks the target.
    function automatic logic [DATA_W-1:0] op_store_data(input mem_op_e op, input logic [DATA_W-1:0] w);
        case (op)
            OP_SB:   return {4{w[7:0]}};
            OP_SH:   return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

    function automatic logic op_misaligned(input mem_op_e op, input logic [1:0] lo);
        case (op)
            OP_LH, OP_LHU, OP_SH: return lo[0];
            OP_LW, OP_SW:         return lo != 2'b00;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_ctrl_load_align.sv
// load_align: combinational load-lane extraction and extension.
// Ports:
//   op      in  3       mem_op_e of the load
//   addr_lo in  2       byte address bits [1:0]
//   ldata   in  DATA_W  raw word from data_ram
//   result  out DATA_W  LB/LH sign-extended, LBU/LHU zero-extended, LW as-is
module load_align
    import data_mem_ctrl_pkg::*;
(
    input  logic [2:0]        op,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] ldata,
    output logic [DATA_W-1:0] result
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = ldata[7:0];
        case (addr_lo)
            2'd1:    byte_v = ldata[15:8];
            2'd2:    byte_v = ldata[23:16];
            2'd3:    byte_v = ldata[31:24];
            default: byte_v = ldata[7:0];
        endcase
        // addr_lo[0] is deliberately ignored for halves (truncation rule)
        half_v = addr_lo[1] ? ldata[31:16] : ldata[15:0];
    end

    always_comb begin
        result = ldata;
        case (mem_op_e'(op))
            OP_LB:   result = {{(DATA_W-8){byte_v[7]}}, byte_v};
            OP_LBU:  result = {{(DATA_W-8){1'b0}}, byte_v};
            OP_LH:   result = {{(DATA_W-16){half_v[15]}}, half_v};
            OP_LHU:  result = {{(DATA_W-16){1'b0}}, half_v};
            default: result = ldata;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: MEM-stage initiator for a combinational-read,
// posedge-write data_ram. One request in flight: IDLE -> ACCESS -> RESP.
// Ports:
//   CLK, RST_N (async, active-low)
//   REQ_VALID/REQ_READY/REQ_OP/REQ_ADDR/REQ_WDATA/REQ_TAG : request side
//   RESP_VALID/RESP_READY/RESP_DATA/RESP_TAG/RESP_EXC      : response side
//   CEN/WEN/ADDR/BYTE_SEL/SDATA -> data_ram, LDATA <- data_ram
// Build option: define DATA_MEM_CTRL_ALIGN_CHECK_EN to trap misaligned
// requests (no RAM access, RESP_EXC=1, RESP_DATA=faulting address).
// Without it, misaligned requests proceed using truncated lane selection.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   REQ_VALID,
    output logic                   REQ_READY,
    input  logic [2:0]             REQ_OP,
    input  logic [DATA_ADDR_W-1:0] REQ_ADDR,
    input  logic [DATA_W-1:0]      REQ_WDATA,
    input  logic [TAG_W-1:0]       REQ_TAG,
    output logic                   RESP_VALID,
    input  logic                   RESP_READY,
    output logic [DATA_W-1:0]      RESP_DATA,
    output logic [TAG_W-1:0]       RESP_TAG,
    output logic                   RESP_EXC,
    output logic                   CEN,
    output logic                   WEN,
    output logic [DATA_ADDR_W-1:0] ADDR,
    output logic [3:0]             BYTE_SEL,
    output logic [DATA_W-1:0]      SDATA,
    input  logic [DATA_W-1:0]      LDATA
);

    state_e              state, state_nxt;
    mem_req_t            req_p0;
    logic [TAG_W-1:0]    tag_p0;
    logic [DATA_W-1:0]   load_result;
    logic                req_fire;
    logic                bad_req;

    assign req_fire = REQ_VALID && REQ_READY;

`ifdef DATA_MEM_CTRL_ALIGN_CHECK_EN
    assign bad_req = op_misaligned(mem_op_e'(REQ_OP), REQ_ADDR[1:0]);
`else
    assign bad_req = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        REQ_READY = 1'b0;
        case (state)
            IDLE: begin
                REQ_READY = 1'b1;
                if (REQ_VALID) state_nxt = bad_req ? RESP : ACCESS;
            end
            ACCESS:  state_nxt = RESP;
            RESP:    if (RESP_READY) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign RESP_VALID = (state == RESP);

    // Stage p0: request captured at accept; data only, no reset needed
    always_ff @(posedge CLK) begin
        if (req_fire) begin
            req_p0.op    <= mem_op_e'(REQ_OP);
            req_p0.addr  <= REQ_ADDR;
            req_p0.wdata <= REQ_WDATA;
            tag_p0       <= REQ_TAG;
        end
    end

    // RAM strobes are combinational from state so an async reset drops
    // CEN in the same instant and an in-flight store never commits.
    always_comb begin
        CEN      = CDISABLE;
        WEN      = WDISABLE;
        ADDR     = '0;
        BYTE_SEL = '0;
        SDATA    = '0;
        if (state == ACCESS) begin
            CEN      = CENABLE;
            WEN      = op_is_store(req_p0.op) ? WENABLE : WDISABLE;
            ADDR     = req_p0.addr;
            BYTE_SEL = op_lane_sel(req_p0.op, req_p0.addr[1:0]);
            SDATA    = op_is_store(req_p0.op) ? op_store_data(req_p0.op, req_p0.wdata) : '0;
        end
    end

    load_align u_load_align (
        .op      (req_p0.op),
        .addr_lo (req_p0.addr[1:0]),
        .ldata   (LDATA),
        .result  (load_result)
    );

    // Stage p1: response captured at the edge closing ACCESS (or accept
    // of a trapped request); held stable through RESP.
`ifdef DATA_MEM_CTRL_ALIGN_CHECK_EN
    logic resp_exc_p1;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            RESP_DATA   <= '0;
            RESP_TAG    <= '0;
            resp_exc_p1 <= 1'b0;
        end else if (state == ACCESS) begin
            RESP_DATA   <= op_is_store(req_p0.op) ? '0 : load_result;
            RESP_TAG    <= tag_p0;
            resp_exc_p1 <= 1'b0;
        end else if (req_fire && bad_req) begin
            RESP_DATA   <= REQ_ADDR;
            RESP_TAG    <= REQ_TAG;
            resp_exc_p1 <= 1'b1;
        end
    end

    assign RESP_EXC = resp_exc_p1;
`else
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            RESP_DATA <= '0;
            RESP_TAG  <= '0;
        end else if (state == ACCESS) begin
            RESP_DATA <= op_is_store(req_p0.op) ? '0 : load_result;
            RESP_TAG  <= tag_p0;
        end
    end

    assign RESP_EXC = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with a byte-lane data_ram model.
// Responses are checked by a scoreboard monitor; RAM-side strobes and
// memory contents are checked inline by the stimulus thread.
module tb_data_mem_ctrl;
    import data_mem_ctrl_pkg::*;

    logic        CLK;
    logic        RST_N;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic [2:0]  REQ_OP;
    logic [31:0] REQ_ADDR;
    logic [31:0] REQ_WDATA;
    logic [4:0]  REQ_TAG;
    logic        RESP_VALID;
    logic        RESP_READY;
    logic [31:0] RESP_DATA;
    logic [4:0]  RESP_TAG;
    logic        RESP_EXC;
    logic        CEN;
    logic        WEN;
    logic [31:0] ADDR;
    logic [3:0]  BYTE_SEL;
    logic [31:0] SDATA;
    logic [31:0] LDATA;

    data_mem_ctrl #(.TAG_W(5)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP),
        .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_TAG(REQ_TAG),
        .RESP_VALID(RESP_VALID), .RESP_READY(RESP_READY), .RESP_DATA(RESP_DATA),
        .RESP_TAG(RESP_TAG), .RESP_EXC(RESP_EXC),
        .CEN(CEN), .WEN(WEN), .ADDR(ADDR), .BYTE_SEL(BYTE_SEL),
        .SDATA(SDATA), .LDATA(LDATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // data_ram model: 16 words, combinational read, posedge lane write
    logic [31:0] ram [0:15];
    logic [31:0] merged;
    logic        preload;

    assign LDATA = ram[ADDR[5:2]];

    always_comb begin
        merged = ram[ADDR[5:2]];
        for (int i = 0; i < 4; i++)
            if (BYTE_SEL[i]) merged[8*i +: 8] = SDATA[8*i +: 8];
    end

    always @(posedge CLK) begin
        if (preload) begin
            for (int k = 0; k < 16; k++) ram[k] <= 32'h0;
            ram[0] <= 32'hCAFEF00D;
            ram[1] <= 32'h11223344;
            ram[3] <= 32'h55AA55AA;
        end else if (CEN == CENABLE && WEN == WENABLE) begin
            ram[ADDR[5:2]] <= merged;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
        logic        exc;
    } exp_t;

    exp_t sbq[$];

    // Monitor: one pop per response handshake (sampled mid-cycle)
    always @(negedge CLK) begin
        if (RESP_VALID && RESP_READY) begin
            if (sbq.size() == 0) begin
                check("unexpected_resp", {27'b0, RESP_TAG}, 32'hFFFFFFFF);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("resp_data", RESP_DATA, e.data);
                check("resp_tag", {27'b0, RESP_TAG}, {27'b0, e.tag});
                check("resp_exc", {31'b0, RESP_EXC}, {31'b0, e.exc});
            end
        end
    end

    // Issue one request; returns at posedge+1 of the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] tag, input logic [31:0] exp_data, input logic exp_exc,
                         input logic push);
        int n;
        exp_t e;
        @(negedge CLK);
        REQ_VALID = 1'b1;
        REQ_OP    = op;
        REQ_ADDR  = addr;
        REQ_WDATA = wdata;
        REQ_TAG   = tag;
        n = 0;
        while (!REQ_READY && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (!REQ_READY) check("req_accept_timeout", 32'd0, 32'd1);
        if (push) begin
            e.data = exp_data;
            e.tag  = tag;
            e.exc  = exp_exc;
            sbq.push_back(e);
        end
        @(posedge CLK);
        #1;
        REQ_VALID = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        RST_N      = 1'b0;
        preload    = 1'b1;
        REQ_VALID  = 1'b0;
        REQ_OP     = 3'd0;
        REQ_ADDR   = 32'h0;
        REQ_WDATA  = 32'h0;
        REQ_TAG    = 5'd0;
        RESP_READY = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        preload = 1'b0;
        check("rst_resp_valid", {31'b0, RESP_VALID}, 32'd0);
        check("rst_resp_data", RESP_DATA, 32'd0);
        check("rst_resp_tag", {27'b0, RESP_TAG}, 32'd0);
        check("rst_resp_exc", {31'b0, RESP_EXC}, 32'd0);
        check("rst_req_ready", {31'b0, REQ_READY}, 32'd1);
        check("rst_cen", {31'b0, CEN}, {31'b0, CDISABLE});
        check("rst_wen", {31'b0, WEN}, {31'b0, WDISABLE});
        check("rst_addr", ADDR, 32'd0);
        check("rst_bytesel", {28'b0, BYTE_SEL}, 32'd0);
        check("rst_sdata", SDATA, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        // SW 0x8 DEADBEEF
        issue(OP_SW, 32'h8, 32'hDEADBEEF, 5'd1, 32'h0, 1'b0, 1'b1);
        check("sw_cen", {31'b0, CEN}, {31'b0, CENABLE});
        check("sw_wen", {31'b0, WEN}, {31'b0, WENABLE});
        check("sw_bytesel", {28'b0, BYTE_SEL}, 32'hF);
        check("sw_addr", ADDR, 32'h8);
        check("sw_sdata", SDATA, 32'hDEADBEEF);
        check("sw_req_ready_busy", {31'b0, REQ_READY}, 32'd0);
        @(posedge CLK);
        #1;
        check("sw_ram_word2", ram[2], 32'hDEADBEEF);

        // LW 0x8, response visible two edges after accept
        issue(OP_LW, 32'h8, 32'h0, 5'd2, 32'hDEADBEEF, 1'b0, 1'b1);
        check("lw_wen", {31'b0, WEN}, {31'b0, WDISABLE});
        check("lw_bytesel", {28'b0, BYTE_SEL}, 32'hF);
        check("lw_valid_lat1", {31'b0, RESP_VALID}, 32'd0);
        @(posedge CLK);
        #1;
        check("lw_valid_lat2", {31'b0, RESP_VALID}, 32'd1);
        check("lw_data_lat2", RESP_DATA, 32'hDEADBEEF);

        // SB 0x5 0x80 into word 1 (0x11223344)
        issue(OP_SB, 32'h5, 32'h80, 5'd3, 32'h0, 1'b0, 1'b1);
        check("sb_bytesel", {28'b0, BYTE_SEL}, 32'h2);
        check("sb_sdata", SDATA, 32'h80808080);
        @(posedge CLK);
        #1;
        check("sb_ram_word1", ram[1], 32'h11228044);

        issue(OP_LB, 32'h5, 32'h0, 5'd4, 32'hFFFFFF80, 1'b0, 1'b1);
        check("lb_bytesel", {28'b0, BYTE_SEL}, 32'h2);
        issue(OP_LBU, 32'h5, 32'h0, 5'd5, 32'h00000080, 1'b0, 1'b1);

        // SH 0x6 0x1234ABCD -> word 1 becomes ABCD8044
        issue(OP_SH, 32'h6, 32'h1234ABCD, 5'd6, 32'h0, 1'b0, 1'b1);
        check("sh_bytesel", {28'b0, BYTE_SEL}, 32'hC);
        check("sh_sdata", SDATA, 32'hABCDABCD);
        @(posedge CLK);
        #1;
        check("sh_ram_word1", ram[1], 32'hABCD8044);

        issue(OP_LHU, 32'h6, 32'h0, 5'd7, 32'h0000ABCD, 1'b0, 1'b1);
        issue(OP_LH, 32'h6, 32'h0, 5'd8, 32'hFFFFABCD, 1'b0, 1'b1);
        issue(OP_LH, 32'h4, 32'h0, 5'd9, 32'hFFFF8044, 1'b0, 1'b1);
        check("lh_lo_bytesel", {28'b0, BYTE_SEL}, 32'h3);

        // Back-pressure: RESP_READY low for 5 cycles
        n = 0;
        @(negedge CLK);
        while (!REQ_READY && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("stall_pre_idle", {31'b0, REQ_READY}, 32'd1);
        RESP_READY = 1'b0;
        issue(OP_LW, 32'h8, 32'h0, 5'd10, 32'hDEADBEEF, 1'b0, 1'b1);
        @(posedge CLK);
        #1;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            check("stall_valid", {31'b0, RESP_VALID}, 32'd1);
            check("stall_data", RESP_DATA, 32'hDEADBEEF);
            check("stall_tag", {27'b0, RESP_TAG}, 32'd10);
            check("stall_req_ready", {31'b0, REQ_READY}, 32'd0);
            check("stall_cen", {31'b0, CEN}, {31'b0, CDISABLE});
        end
        @(posedge CLK);
        #1;
        RESP_READY = 1'b1;

        // Misaligned LW 0x3 (word 0 = CAFEF00D)
`ifdef DATA_MEM_CTRL_ALIGN_CHECK_EN
        issue(OP_LW, 32'h3, 32'h0, 5'd11, 32'h3, 1'b1, 1'b1);
        check("mis_cen", {31'b0, CEN}, {31'b0, CDISABLE});
        check("mis_valid_lat1", {31'b0, RESP_VALID}, 32'd1);
        check("mis_exc", {31'b0, RESP_EXC}, 32'd1);
`else
        issue(OP_LW, 32'h3, 32'h0, 5'd11, 32'hCAFEF00D, 1'b0, 1'b1);
        check("mis_cen", {31'b0, CEN}, {31'b0, CENABLE});
        check("mis_bytesel", {28'b0, BYTE_SEL}, 32'hF);
`endif

        // Reset during ACCESS of SW 0xC: store dropped, response discarded
        issue(OP_SW, 32'hC, 32'h01020304, 5'd12, 32'h0, 1'b0, 1'b0);
        check("rstmid_cen_on", {31'b0, CEN}, {31'b0, CENABLE});
        #2;
        RST_N = 1'b0;
        #1;
        check("rstmid_cen_off", {31'b0, CEN}, {31'b0, CDISABLE});
        check("rstmid_resp_valid", {31'b0, RESP_VALID}, 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        check("rstmid_ram_word3", ram[3], 32'h55AA55AA);
        check("rstmid_req_ready", {31'b0, REQ_READY}, 32'd1);
        check("rstmid_valid_after", {31'b0, RESP_VALID}, 32'd0);

        issue(OP_LW, 32'hC, 32'h0, 5'd13, 32'h55AA55AA, 1'b0, 1'b1);

        n = 0;
        while (sbq.size() != 0 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check("sb_drain", sbq.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
